seg7_scan_ctrl: RTL

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

---
 rtl/seg7_pkg.sv | 13 +
 rtl/seg7_hex_decode.sv | 11 +
 rtl/seg7_scan_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan controller: the hex glyph table
// (active-low, bit0 = a ... bit6 = g) and the all-segments-off pattern.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Index 0 sits in the rightmost slot; glyphs F..0 run left to right.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph lookup.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed seven-segment scanner with tear-free double-buffered loads,
// leading-zero blanking and per-digit blink.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 250
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    blank_lz,
  output logic [6:0]              Cnode,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   dp_mask;
    logic [NUM_DIGITS-1:0]   blink_mask;
  } disp_t;

  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx, idx_n;
  logic [BLK_W-1:0] blk_cnt;
  logic             phase, phase_n;
  logic             pending;
  disp_t            shadow, active, active_n;
  logic             tick, wrap;

  assign tick       = (cnt == CNT_W'(REFRESH_DIV - 1));
  assign wrap       = tick && (idx == IDX_W'(NUM_DIGITS - 1));
  assign frame_done = wrap;

  always_comb begin
    idx_n = idx;
    if (tick) idx_n = wrap ? '0 : idx + IDX_W'(1);
  end

  // Shadow only reaches the display at a frame boundary, so a frame never mixes old and new data.
  assign active_n = (wrap && pending) ? shadow : active;
  assign phase_n  = (wrap && blk_cnt == BLK_W'(BLINK_DIV - 1)) ? ~phase : phase;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      blk_cnt <= '0;
      phase   <= 1'b1;
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      cnt    <= tick ? '0 : cnt + CNT_W'(1);
      idx    <= idx_n;
      phase  <= phase_n;
      active <= active_n;
      if (wrap) blk_cnt <= (blk_cnt == BLK_W'(BLINK_DIV - 1)) ? '0 : blk_cnt + BLK_W'(1);
      // A load on the commit edge refills the shadow and keeps pending set.
      if (load) begin
        shadow  <= {value, dp_mask, blink_mask};
        pending <= 1'b1;
      end else if (wrap) begin
        pending <= 1'b0;
      end
    end
  end

  logic [3:0] nib;
  logic [6:0] hex_seg;
  logic       lz_blank, blink_blank;

  // Output registers are fed from next-state values so they track the index one cycle after the tick.
  assign nib = active_n.value[{idx_n, 2'b00} +: 4];

  seg7_hex_decode u_dec (
    .hex (nib),
    .seg (hex_seg)
  );

  assign lz_blank    = blank_lz && (idx_n != '0) &&
                       ((active_n.value >> {idx_n, 2'b00}) == '0);
  assign blink_blank = ~phase_n & active_n.blink_mask[idx_n];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      AN    <= '1;
      Cnode <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      AN <= ~(NUM_DIGITS'(1) << idx_n);
      if (lz_blank || blink_blank) begin
        Cnode <= SEG_BLANK;
        dp    <= 1'b1;
      end else begin
        Cnode <= hex_seg;
        dp    <= ~active_n.dp_mask[idx_n];
      end
    end
  end

endmodule
